// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard for the RV32IF pipeline, with sequencing and writeback handshake
// for the shared multi-cycle FP unit. Optional stall statistics: define HAZARD_SB_STATS_EN.
module hazard_scoreboard #(
    parameter int MC_LAT = 8,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [6:0]  opcode_ID,
    input  logic [6:0]  funct7_ID,
    input  logic [5:0]  rs1_addr_ID,
    input  logic [5:0]  rs2_addr_ID,
    input  logic [5:0]  rd_addr_ID,
    input  logic        mem_wait,
    input  logic        flush_EX,
    input  logic        flush_all,
    input  logic        wb_valid,
    input  logic [5:0]  wb_rd_addr,
    input  logic        mc_ack,
    output logic        stall_ID,
    output logic        mc_start,
    output logic        mc_busy,
    output logic        mc_done,
    output logic [5:0]  mc_rd_addr,
    output logic [31:0] stall_cnt
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FALU   = 7'b1010011;
    localparam logic [6:0] OP_CSR    = 7'b1110011;
    localparam logic [6:0] F7_FDIV   = 7'b0001100;
    localparam logic [6:0] F7_FSQRT  = 7'b0101100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_t;

    mc_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [5:0]       mc_rd_r;
    logic             mc_busy_r;
    logic             mc_done_r;
    logic [63:0]      pending_r;

    logic        uses_rs1_s, uses_rs2_s, wr_op_s, is_falu_s, is_ld_s;
    logic        writes_rd_s, is_mc_s, tracked_s;
    logic        raw_s, waw_s, struct_s, fire_s, ack_done_s;
    logic [63:0] wb_mask_s, mc_mask_s, set_mask_s, eff_s, pending_nxt_s;

    // Opcode class decode of the ID-stage instruction.
    always_comb begin
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        wr_op_s    = 1'b0;
        is_falu_s  = 1'b0;
        is_ld_s    = 1'b0;
        case (opcode_ID)
            OP_RTYPE:  begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; wr_op_s = 1'b1; end
            OP_ITYPE:  begin uses_rs1_s = 1'b1; wr_op_s = 1'b1; end
            OP_LOAD:   begin uses_rs1_s = 1'b1; wr_op_s = 1'b1; is_ld_s = 1'b1; end
            OP_STORE:  begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OP_BRANCH: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OP_JALR:   begin uses_rs1_s = 1'b1; wr_op_s = 1'b1; end
            OP_JAL:    begin wr_op_s = 1'b1; end
            OP_AUIPC:  begin wr_op_s = 1'b1; end
            OP_LUI:    begin wr_op_s = 1'b1; end
            OP_FLW:    begin uses_rs1_s = 1'b1; wr_op_s = 1'b1; is_ld_s = 1'b1; end
            OP_FSW:    begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OP_FALU: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = (funct7_ID != F7_FSQRT);
                wr_op_s    = 1'b1;
                is_falu_s  = 1'b1;
            end
            OP_CSR:    begin uses_rs1_s = 1'b1; wr_op_s = 1'b1; end
            default:   begin uses_rs1_s = 1'b0; end
        endcase
    end

    // Integer x0 is never tracked; FP f0 (6'd32) is a real register.
    assign writes_rd_s = wr_op_s & (rd_addr_ID != 6'd0);
    assign is_mc_s     = is_falu_s & ((funct7_ID == F7_FDIV) | (funct7_ID == F7_FSQRT));
    assign tracked_s   = (is_ld_s | is_mc_s) & writes_rd_s;

    // Same-cycle writebacks are masked out so the dependent instruction issues without a bubble.
    assign ack_done_s = mc_done_r & mc_ack;
    assign wb_mask_s  = wb_valid   ? (64'd1 << wb_rd_addr) : 64'd0;
    assign mc_mask_s  = ack_done_s ? (64'd1 << mc_rd_r)    : 64'd0;
    assign eff_s      = pending_r & ~wb_mask_s & ~mc_mask_s;

    assign raw_s    = (uses_rs1_s & eff_s[rs1_addr_ID]) | (uses_rs2_s & eff_s[rs2_addr_ID]);
    assign waw_s    = writes_rd_s & eff_s[rd_addr_ID];
    assign struct_s = is_mc_s & (state_r != ST_IDLE) & ~ack_done_s;

    assign stall_ID = id_valid & (raw_s | waw_s | struct_s);
    assign fire_s   = id_valid & ~stall_ID & ~mem_wait & ~flush_EX & ~flush_all;
    assign mc_start = fire_s & is_mc_s;

    // Set wins over a same-index clear; flush_all wipes everything.
    assign set_mask_s    = (fire_s & tracked_s) ? (64'd1 << rd_addr_ID) : 64'd0;
    assign pending_nxt_s = flush_all ? 64'd0 : (eff_s | set_mask_s);

    // Pending-write scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 64'd0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Multi-cycle FP unit sequencer: IDLE -> BUSY (MC_LAT cycles) -> DONE until acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            mc_rd_r   <= 6'd0;
            mc_busy_r <= 1'b0;
            mc_done_r <= 1'b0;
        end else if (flush_all) begin
            state_r   <= ST_IDLE;
            mc_busy_r <= 1'b0;
            mc_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mc_start) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= CNT_W'(MC_LAT - 1);
                        mc_rd_r   <= rd_addr_ID;
                        mc_busy_r <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r   <= ST_DONE;
                        mc_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (mc_ack && mc_start) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= CNT_W'(MC_LAT - 1);
                        mc_rd_r   <= rd_addr_ID;
                        mc_done_r <= 1'b0;
                    end else if (mc_ack) begin
                        state_r   <= ST_IDLE;
                        mc_busy_r <= 1'b0;
                        mc_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mc_busy_r <= 1'b0;
                    mc_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign mc_busy    = mc_busy_r;
    assign mc_done    = mc_done_r;
    assign mc_rd_addr = mc_rd_r;

`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_cnt_r;

    // Stall-cycle statistics; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_ID) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a register-set / timestamp model.
module tb_hazard_scoreboard;

    localparam int MC_LAT = 8;
    localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, LOAD = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, JALR = 7'b1100111;
    localparam logic [6:0] JAL = 7'b1101111, AUIPC = 7'b0010111, LUI = 7'b0110111;
    localparam logic [6:0] FLW = 7'b0000111, FSW = 7'b0100111, FALU = 7'b1010011;
    localparam logic [6:0] CSR = 7'b1110011, FDIV = 7'b0001100, FSQRT = 7'b0101100;

    logic        clk = 1'b0, rst = 1'b1;
    logic        id_valid = 1'b0, mem_wait = 1'b0, flush_EX = 1'b0, flush_all = 1'b0;
    logic [6:0]  opcode_ID = 7'd0, funct7_ID = 7'd0;
    logic [5:0]  rs1_addr_ID = 6'd0, rs2_addr_ID = 6'd0, rd_addr_ID = 6'd0, wb_rd_addr = 6'd0;
    logic        wb_valid = 1'b0, mc_ack = 1'b0;
    logic        stall_ID, mc_start, mc_busy, mc_done;
    logic [5:0]  mc_rd_addr;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad = 0;

    hazard_scoreboard #(.MC_LAT(MC_LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode_ID(opcode_ID), .funct7_ID(funct7_ID),
        .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID), .rd_addr_ID(rd_addr_ID),
        .mem_wait(mem_wait), .flush_EX(flush_EX), .flush_all(flush_all), .wb_valid(wb_valid),
        .wb_rd_addr(wb_rd_addr), .mc_ack(mc_ack), .stall_ID(stall_ID), .mc_start(mc_start),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd_addr(mc_rd_addr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural meaning of an instruction, straight from the opcode class lists.
    function automatic void dec(input logic [6:0] op, input logic [6:0] f7, input logic [5:0] rd,
                                output bit u1, output bit u2, output bit wr, output bit mc,
                                output bit trk);
        bit falu;
        falu = (op == FALU);
        u1   = op inside {RTYPE, ITYPE, LOAD, STORE, BRANCH, JALR, FLW, FSW, FALU, CSR};
        u2   = (op inside {RTYPE, STORE, BRANCH, FSW}) || (falu && f7 != FSQRT);
        wr   = (op inside {RTYPE, ITYPE, LOAD, JALR, JAL, AUIPC, LUI, FLW, FALU, CSR}) && rd != 6'd0;
        mc   = falu && (f7 == FDIV || f7 == FSQRT);
        trk  = (op == LOAD || op == FLW || mc) && wr;
    endfunction

    // Model: set of outstanding registers plus the cycle number at which the FP result appears.
    bit          m_pend [64];
    bit          m_act;
    int          m_done_at;
    logic [5:0]  m_rd;
    logic [31:0] m_stat;
    int          cyc = 0;

    // Per-cycle comparison against the model; inputs are stable at the falling edge.
    always @(negedge clk) begin
        bit u1, u2, wr, mc, trk, m_done, ack, raw, waw, st, exp_stall, fire;
        bit eff [64];
        logic [31:0] exp_cnt;
        if (rst) begin
            chk("rst_stall", {31'd0, stall_ID}, 32'd0);
            chk("rst_start", {31'd0, mc_start}, 32'd0);
            chk("rst_busy", {31'd0, mc_busy}, 32'd0);
            chk("rst_done", {31'd0, mc_done}, 32'd0);
            chk("rst_rd", {26'd0, mc_rd_addr}, 32'd0);
            chk("rst_cnt", stall_cnt, 32'd0);
            for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
            m_act = 1'b0; m_done_at = 0; m_rd = 6'd0; m_stat = 32'd0;
        end else begin
            dec(opcode_ID, funct7_ID, rd_addr_ID, u1, u2, wr, mc, trk);
            m_done = m_act && (cyc >= m_done_at);
            ack = m_done && mc_ack;
            for (int i = 0; i < 64; i++)
                eff[i] = m_pend[i] && !(wb_valid && wb_rd_addr == 6'(i)) && !(ack && m_rd == 6'(i));
            raw = (u1 && eff[rs1_addr_ID]) || (u2 && eff[rs2_addr_ID]);
            waw = wr && eff[rd_addr_ID];
            st = mc && m_act && !ack;
            exp_stall = id_valid && (raw || waw || st);
            fire = id_valid && !exp_stall && !mem_wait && !flush_EX && !flush_all;
`ifdef HAZARD_SB_STATS_EN
            exp_cnt = m_stat;
`else
            exp_cnt = 32'd0;
`endif
            chk("stall_ID", {31'd0, stall_ID}, {31'd0, exp_stall});
            chk("mc_start", {31'd0, mc_start}, {31'd0, fire && mc});
            chk("mc_busy", {31'd0, mc_busy}, {31'd0, m_act});
            chk("mc_done", {31'd0, mc_done}, {31'd0, m_done});
            chk("mc_rd_addr", {26'd0, mc_rd_addr}, {26'd0, m_rd});
            chk("stall_cnt", stall_cnt, exp_cnt);
            if (exp_stall) m_stat = m_stat + 32'd1;
            if (flush_all) begin
                for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
                m_act = 1'b0;
            end else begin
                for (int i = 0; i < 64; i++) m_pend[i] = eff[i];
                if (fire && trk) m_pend[rd_addr_ID] = 1'b1;
                if (ack) m_act = 1'b0;
                if (fire && mc) begin
                    m_act = 1'b1;
                    m_done_at = cyc + MC_LAT + 1;
                    m_rd = rd_addr_ID;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 1'b0; mem_wait = 1'b0; flush_EX = 1'b0; flush_all = 1'b0;
        wb_valid = 1'b0; mc_ack = 1'b0;
    endtask

    task automatic put(input logic [6:0] op, input logic [6:0] f7, input logic [5:0] r1,
                       input logic [5:0] r2, input logic [5:0] rd);
        id_valid = 1'b1; opcode_ID = op; funct7_ID = f7;
        rs1_addr_ID = r1; rs2_addr_ID = r2; rd_addr_ID = rd;
    endtask

    function automatic logic [5:0] rnd_reg();
        return 6'(($urandom_range(0, 1) << 5) | $urandom_range(0, 3));
    endfunction

    logic [6:0] ops [14];

    initial begin
        ops = '{RTYPE, ITYPE, LOAD, STORE, BRANCH, JALR, JAL, AUIPC, LUI, FLW, FSW, FALU, CSR,
                7'b1111111};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Load-use: lw x5, then add x6,x5,x1 with the writeback two cycles later.
        put(LOAD, 7'd0, 6'd1, 6'd0, 6'd5); #1 chk("lu_issue", {31'd0, stall_ID}, 32'd0);
        step(); clr(); put(RTYPE, 7'd0, 6'd5, 6'd1, 6'd6); #1 chk("lu_stall1", {31'd0, stall_ID}, 32'd1);
        step(); #1 chk("lu_stall2", {31'd0, stall_ID}, 32'd1);
        step(); wb_valid = 1'b1; wb_rd_addr = 6'd5; #1 chk("lu_wb", {31'd0, stall_ID}, 32'd0);
        step(); wb_valid = 1'b0; #1 chk("lu_cleared", {31'd0, stall_ID}, 32'd0);

        // x0 untracked; FP f0 tracked.
        step(); clr(); put(LOAD, 7'd0, 6'd1, 6'd0, 6'd0);
        step(); put(RTYPE, 7'd0, 6'd0, 6'd0, 6'd1); #1 chk("x0_nostall", {31'd0, stall_ID}, 32'd0);
        step(); put(FLW, 7'd0, 6'd1, 6'd0, 6'd32);
        step(); put(FALU, 7'd0, 6'd32, 6'd34, 6'd33); #1 chk("f0_stall", {31'd0, stall_ID}, 32'd1);
        step(); wb_valid = 1'b1; wb_rd_addr = 6'd32; #1 chk("f0_wb", {31'd0, stall_ID}, 32'd0);

        // fdiv f3 at T; done at T+9; fsqrt waits on the unit and issues with the ack.
        step(); clr(); put(FALU, FDIV, 6'd33, 6'd34, 6'd35); #1 chk("mc_start_T", {31'd0, mc_start}, 32'd1);
        for (int k = 1; k <= MC_LAT; k++) begin
            step(); clr(); #1 chk("mc_busy_wait", {30'd0, mc_busy, mc_done}, 32'd2);
        end
        step(); put(FALU, FSQRT, 6'd36, 6'd0, 6'd37);
        #1 chk("mc_done_T9", {25'd0, mc_done, mc_rd_addr}, {25'd0, 1'b1, 6'd35});
        chk("struct_T9", {31'd0, stall_ID}, 32'd1);
        step(); #1 chk("struct_T10", {31'd0, stall_ID}, 32'd1);
        step(); mc_ack = 1'b1; #1 chk("ack_issue", {30'd0, stall_ID, mc_start}, 32'd1);
        step(); clr(); #1 chk("back2back", {24'd0, mc_busy, mc_done, mc_rd_addr}, {24'd0, 2'b10, 6'd37});
        step(); flush_all = 1'b1;
        step(); clr(); put(FALU, 7'd0, 6'd37, 6'd35, 6'd38);
        #1 chk("flush_all", {29'd0, mc_busy, mc_done, stall_ID}, 32'd0);

        // Same-cycle writeback and new set on x7: set wins.
        step(); clr(); put(LOAD, 7'd0, 6'd1, 6'd0, 6'd7);
        step(); clr(); put(LOAD, 7'd0, 6'd2, 6'd0, 6'd7); wb_valid = 1'b1; wb_rd_addr = 6'd7;
        #1 chk("waw_masked", {31'd0, stall_ID}, 32'd0);
        step(); clr(); put(RTYPE, 7'd0, 6'd7, 6'd1, 6'd8); #1 chk("set_over_clr", {31'd0, stall_ID}, 32'd1);
        step(); wb_valid = 1'b1; wb_rd_addr = 6'd7; #1 chk("x7_wb", {31'd0, stall_ID}, 32'd0);

        // flush_EX kills lw x9.
        step(); clr(); put(LOAD, 7'd0, 6'd1, 6'd0, 6'd9); flush_EX = 1'b1;
        step(); clr(); put(RTYPE, 7'd0, 6'd9, 6'd1, 6'd10); #1 chk("flushex", {31'd0, stall_ID}, 32'd0);

        // Asynchronous reset between edges while BUSY.
        step(); clr(); put(FALU, FDIV, 6'd1, 6'd2, 6'd40);
        step(); clr();
        step(); #1 chk("pre_rst_busy", {31'd0, mc_busy}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("async_rst", {mc_busy, mc_done, mc_start, stall_ID, 22'd0, mc_rd_addr}, 32'd0);
        chk("async_rst_cnt", stall_cnt, 32'd0);
        step(); step(); rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step();
            id_valid    = ($urandom_range(0, 99) < 80);
            opcode_ID   = ops[$urandom_range(0, 13)];
            case ($urandom_range(0, 2))
                0: funct7_ID = FDIV;
                1: funct7_ID = FSQRT;
                default: funct7_ID = 7'd0;
            endcase
            rs1_addr_ID = rnd_reg();
            rs2_addr_ID = rnd_reg();
            rd_addr_ID  = rnd_reg();
            mem_wait    = ($urandom_range(0, 99) < 10);
            flush_EX    = ($urandom_range(0, 99) < 5);
            flush_all   = ($urandom_range(0, 99) < 2);
            wb_valid    = ($urandom_range(0, 99) < 30);
            wb_rd_addr  = rnd_reg();
            mc_ack      = ($urandom_range(0, 99) < 40);
        end
        step(); clr();
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
